// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB write-back and decode read-port bundle for wb_regfile
interface wb_regfile_if #(
    parameter int XLEN = 32,
    parameter int IW   = 5
);
    logic            regwrite_WB;
    logic            memread_WB;
    logic [IW-1:0]   rd_WB;
    logic [2:0]      funct3_WB;
    logic [1:0]      addr_lo_WB;
    logic [XLEN-1:0] ALU_data_WB;
    logic [XLEN-1:0] mem_data_WB;
    logic [IW-1:0]   rs1_ID;
    logic [IW-1:0]   rs2_ID;
    logic [XLEN-1:0] rs1_data_ID;
    logic [XLEN-1:0] rs2_data_ID;
    logic [XLEN-1:0] wb_data;
    logic            wb_valid;

    modport master (
        output regwrite_WB, memread_WB, rd_WB, funct3_WB, addr_lo_WB,
               ALU_data_WB, mem_data_WB, rs1_ID, rs2_ID,
        input  rs1_data_ID, rs2_data_ID, wb_data, wb_valid
    );

    modport slave (
        input  regwrite_WB, memread_WB, rd_WB, funct3_WB, addr_lo_WB,
               ALU_data_WB, mem_data_WB, rs1_ID, rs2_ID,
        output rs1_data_ID, rs2_data_ID, wb_data, wb_valid
    );
endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select/align, 32x32 register file with write-through read ports
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    wb_regfile_if.slave wb
);
    localparam int IW = $clog2(NREGS);

    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];

    logic [XLEN-1:0] lane;
    logic [15:0]     half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wb_data;
    logic            wb_valid;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    // Halfwords only sit on even offsets, so the low address bit is ignored.
    always_comb begin
        lane      = wb.mem_data_WB >> {wb.addr_lo_WB, 3'b000};
        half      = wb.addr_lo_WB[1] ? wb.mem_data_WB[31:16] : wb.mem_data_WB[15:0];
        load_data = wb.mem_data_WB;
        case (wb.funct3_WB)
            3'b000:  load_data = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b001:  load_data = {{(XLEN-16){half[15]}}, half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half};
            default: load_data = wb.mem_data_WB;
        endcase
        wb_data  = wb.memread_WB ? load_data : wb.ALU_data_WB;
        wb_valid = wb.regwrite_WB && (wb.rd_WB != '0) && reset;
    end

    always_comb begin
        for (int i = 1; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wb_valid && (wb.rd_WB == IW'(i)))
                regs_d[i] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NREGS; i++)
                regs_q[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++)
                regs_q[i] <= regs_d[i];
        end
    end

    // x0 has no storage: index 0 falls through every match and stays zero.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (wb.rs1_ID == IW'(i)) rs1_data = regs_q[i];
            if (wb.rs2_ID == IW'(i)) rs2_data = regs_q[i];
        end
        if (wb_valid && (wb.rs1_ID == wb.rd_WB)) rs1_data = wb_data;
        if (wb_valid && (wb.rs2_ID == wb.rd_WB)) rs2_data = wb_data;
        if (!reset) begin
            rs1_data = '0;
            rs2_data = '0;
        end
    end

    assign wb.wb_data     = wb_data;
    assign wb.wb_valid    = wb_valid;
    assign wb.rs1_data_ID = rs1_data;
    assign wb.rs2_data_ID = rs2_data;
endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed self-checking bench for wb_regfile
module tb_wb_regfile;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    wb_regfile_if #(.XLEN(32), .IW(5)) bus ();

    wb_regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        bus.regwrite_WB = 1'b0;
        bus.memread_WB  = 1'b0;
        bus.rd_WB       = 5'd0;
        bus.funct3_WB   = 3'b010;
        bus.addr_lo_WB  = 2'd0;
        bus.ALU_data_WB = 32'h0;
        bus.mem_data_WB = 32'h0;
        bus.rs1_ID      = 5'd0;
        bus.rs2_ID      = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        bus.regwrite_WB = 1'b1;
        bus.rd_WB       = 5'd3;
        bus.ALU_data_WB = 32'h0000FFFF;
        bus.rs1_ID      = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_wb_valid got %b exp 0", bus.wb_valid);
        end
        n_checks++;
        if (bus.rs1_data_ID !== 32'h0) begin
            n_fail++; $display("FAIL reset_no_bypass got %h exp 00000000", bus.rs1_data_ID);
        end
        n_checks++;
        if (bus.wb_data !== 32'h0000FFFF) begin
            n_fail++; $display("FAIL reset_wb_data got %h exp 0000ffff", bus.wb_data);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.rs1_ID = 5'(i);
            bus.rs2_ID = 5'(31 - i);
            #1;
            n_checks++;
            if (bus.rs1_data_ID !== 32'h0) begin
                n_fail++; $display("FAIL reset_read_rs1[%0d] got %h exp 00000000", i, bus.rs1_data_ID);
            end
            n_checks++;
            if (bus.rs2_data_ID !== 32'h0) begin
                n_fail++; $display("FAIL reset_read_rs2[%0d] got %h exp 00000000", 31 - i, bus.rs2_data_ID);
            end
        end
    endtask

    task automatic test_alu_write();
        @(negedge clk);
        idle_inputs();
        bus.regwrite_WB = 1'b1;
        bus.rd_WB       = 5'd5;
        bus.ALU_data_WB = 32'hDEADBEEF;
        bus.rs1_ID      = 5'd5;
        bus.rs2_ID      = 5'd6;
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL alu_wb_valid got %b exp 1", bus.wb_valid);
        end
        n_checks++;
        if (bus.rs1_data_ID !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alu_bypass got %h exp deadbeef", bus.rs1_data_ID);
        end
        n_checks++;
        if (bus.rs2_data_ID !== 32'h0) begin
            n_fail++; $display("FAIL alu_other_reg got %h exp 00000000", bus.rs2_data_ID);
        end
        @(negedge clk);
        bus.regwrite_WB = 1'b0;
        bus.ALU_data_WB = 32'h11111111;
        bus.rs2_ID      = 5'd5;
        #1;
        n_checks++;
        if (bus.rs2_data_ID !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alu_stored got %h exp deadbeef", bus.rs2_data_ID);
        end
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL alu_idle_valid got %b exp 0", bus.wb_valid);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        idle_inputs();
        bus.regwrite_WB = 1'b1;
        bus.rd_WB       = 5'd0;
        bus.ALU_data_WB = 32'h12345678;
        bus.rs1_ID      = 5'd0;
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL x0_wb_valid got %b exp 0", bus.wb_valid);
        end
        n_checks++;
        if (bus.rs1_data_ID !== 32'h0) begin
            n_fail++; $display("FAIL x0_same_cycle got %h exp 00000000", bus.rs1_data_ID);
        end
        n_checks++;
        if (bus.wb_data !== 32'h12345678) begin
            n_fail++; $display("FAIL x0_wb_data got %h exp 12345678", bus.wb_data);
        end
        @(negedge clk);
        bus.regwrite_WB = 1'b0;
        #1;
        n_checks++;
        if (bus.rs1_data_ID !== 32'h0) begin
            n_fail++; $display("FAIL x0_next_cycle got %h exp 00000000", bus.rs1_data_ID);
        end
    endtask

    task automatic test_load_align();
        logic [2:0]  f3  [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b010, 3'b111};
        logic [1:0]  off [8] = '{2'd0, 2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0};
        logic [31:0] exp [8] = '{32'h00000001, 32'hFFFFFF80, 32'h000000FF, 32'hFFFF80FF,
                                 32'h00007F01, 32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.regwrite_WB = 1'b1;
            bus.memread_WB  = 1'b1;
            bus.rd_WB       = 5'd10;
            bus.mem_data_WB = 32'h80FF7F01;
            bus.ALU_data_WB = 32'h55555555;
            bus.funct3_WB   = f3[i];
            bus.addr_lo_WB  = off[i];
            bus.rs1_ID      = 5'd10;
            #1;
            n_checks++;
            if (bus.wb_data !== exp[i]) begin
                n_fail++; $display("FAIL load_wb_data[f3=%b off=%0d] got %h exp %h", f3[i], off[i], bus.wb_data, exp[i]);
            end
            n_checks++;
            if (bus.rs1_data_ID !== exp[i]) begin
                n_fail++; $display("FAIL load_bypass[f3=%b off=%0d] got %h exp %h", f3[i], off[i], bus.rs1_data_ID, exp[i]);
            end
        end
        @(negedge clk);
        idle_inputs();
        bus.rs2_ID = 5'd10;
        #1;
        n_checks++;
        if (bus.rs2_data_ID !== 32'h80FF7F01) begin
            n_fail++; $display("FAIL load_stored got %h exp 80ff7f01", bus.rs2_data_ID);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        idle_inputs();
        bus.regwrite_WB = 1'b1;
        bus.rd_WB       = 5'd7;
        bus.ALU_data_WB = 32'h00000001;
        @(negedge clk);
        bus.ALU_data_WB = 32'h00000002;
        bus.rs1_ID      = 5'd7;
        bus.rs2_ID      = 5'd7;
        #1;
        n_checks++;
        if (bus.rs1_data_ID !== 32'h2) begin
            n_fail++; $display("FAIL b2b_c2_rs1 got %h exp 00000002", bus.rs1_data_ID);
        end
        n_checks++;
        if (bus.rs2_data_ID !== 32'h2) begin
            n_fail++; $display("FAIL b2b_c2_rs2 got %h exp 00000002", bus.rs2_data_ID);
        end
        @(negedge clk);
        bus.regwrite_WB = 1'b0;
        bus.ALU_data_WB = 32'h00000003;
        #1;
        n_checks++;
        if (bus.rs1_data_ID !== 32'h2) begin
            n_fail++; $display("FAIL b2b_c3_rs1 got %h exp 00000002", bus.rs1_data_ID);
        end
        n_checks++;
        if (bus.rs2_data_ID !== 32'h2) begin
            n_fail++; $display("FAIL b2b_c3_rs2 got %h exp 00000002", bus.rs2_data_ID);
        end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        idle_inputs();
        bus.regwrite_WB = 1'b1;
        bus.rd_WB       = 5'd9;
        bus.ALU_data_WB = 32'hA5A5A5A5;
        @(negedge clk);
        bus.regwrite_WB = 1'b0;
        bus.rs1_ID      = 5'd9;
        bus.rs2_ID      = 5'd5;
        #1;
        n_checks++;
        if (bus.rs1_data_ID !== 32'hA5A5A5A5) begin
            n_fail++; $display("FAIL rst_pre_value got %h exp a5a5a5a5", bus.rs1_data_ID);
        end
        @(negedge clk);
        bus.regwrite_WB = 1'b1;
        bus.ALU_data_WB = 32'h00000005;
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.rs1_data_ID !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_read got %h exp 00000000", bus.rs1_data_ID);
        end
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_valid got %b exp 0", bus.wb_valid);
        end
        @(negedge clk);
        bus.regwrite_WB = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.rs1_data_ID !== 32'h0) begin
            n_fail++; $display("FAIL rst_after_x9 got %h exp 00000000", bus.rs1_data_ID);
        end
        n_checks++;
        if (bus.rs2_data_ID !== 32'h0) begin
            n_fail++; $display("FAIL rst_after_x5 got %h exp 00000000", bus.rs2_data_ID);
        end
        @(negedge clk);
        bus.regwrite_WB = 1'b1;
        bus.ALU_data_WB = 32'h00000033;
        @(negedge clk);
        bus.regwrite_WB = 1'b0;
        #1;
        n_checks++;
        if (bus.rs1_data_ID !== 32'h33) begin
            n_fail++; $display("FAIL rst_first_write got %h exp 00000033", bus.rs1_data_ID);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_alu_write();
        test_x0();
        test_load_align();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
